// File: rtl/note_lane_engine.sv
// Note-lane rhythm engine: shifts per-lane song patterns one position per step,
// scores player notes against the hit column and redraws the lane boxes pixel by pixel.
module note_lane_engine #(
  parameter int LANES    = 3,
  parameter int BOXES    = 4,
  parameter int SONG_LEN = 115,
  parameter int BOX_W    = 60,
  parameter int BOX_H    = 60,
  parameter int ORIGIN_Y = 60,
  parameter int SCORE_W  = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        step,
  input  logic [LANES*SONG_LEN-1:0]   songPattern,
  input  logic [LANES-1:0]            notes,
  output logic [11:0]                 spriteAddr,
  input  logic [2:0]                  spriteColour,
  output logic [8:0]                  vgaOutX,
  output logic [7:0]                  vgaOutY,
  output logic [2:0]                  vgaOutColour,
  output logic                        plot,
  output logic                        busy,
  output logic                        songDone,
  output logic [SCORE_W-1:0]          score
);

  localparam int LANE_W = 4;
  localparam int BOX_IW = 4;
  localparam int PIX_W  = 9;
  localparam int STEP_W = $clog2(SONG_LEN + 1);
  localparam int SUM_W  = SCORE_W + 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SCORE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [LANES*SONG_LEN-1:0] lanes_q, lanes_d;
  logic [SCORE_W-1:0]        score_q, score_d;
  logic [STEP_W-1:0]         step_cnt_q, step_cnt_d;
  logic                      pending_q, pending_d;
  logic [LANE_W-1:0]         lane_idx_q, lane_idx_d;
  logic [BOX_IW-1:0]         box_q, box_d;
  logic [PIX_W-1:0]          row_q, row_d;
  logic [PIX_W-1:0]          col_q, col_d;
  logic                      drain_q, drain_d;
  logic                      plot_q, plot_d;
  logic                      bit_q, bit_d;
  logic [8:0]                x_q, x_d;
  logic [7:0]                y_q, y_d;
  logic [2:0]                colour_q, colour_d;

  logic                      box_bit;
  logic [3:0]                hits;
  logic [SUM_W-1:0]          score_sum;
  logic [8:0]                pix_x;
  logic [7:0]                pix_y;

  // Shift bit shown by the box currently being scanned; rightmost box is bit 0.
  always_comb begin
    box_bit = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      for (int c = 0; c < BOXES; c++) begin
        if (lane_idx_q == LANE_W'(l) && box_q == BOX_IW'(c)) begin
          box_bit = lanes_q[l*SONG_LEN + BOXES - 1 - c];
        end
      end
    end
  end

  always_comb begin
    hits = '0;
    for (int l = 0; l < LANES; l++) begin
      hits = hits + 4'(lanes_q[l*SONG_LEN] & notes[l]);
    end
    score_sum = SUM_W'(score_q) + SUM_W'(hits);
  end

  assign pix_x = 9'(32'(box_q) * BOX_W + 32'(col_q));
  assign pix_y = 8'(ORIGIN_Y + 32'(lane_idx_q) * BOX_H + 32'(row_q));

  // Sprite data arrives one cycle after its address, so the colour is muxed
  // live during the plot cycle and held afterwards.
  always_comb begin
    if (plot_q) begin
      vgaOutColour = bit_q ? spriteColour : 3'b111;
    end else begin
      vgaOutColour = colour_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    lanes_d    = lanes_q;
    score_d    = score_q;
    step_cnt_d = step_cnt_q;
    pending_d  = pending_q;
    lane_idx_d = lane_idx_q;
    box_d      = box_q;
    row_d      = row_q;
    col_d      = col_q;
    drain_d    = drain_q;
    plot_d     = 1'b0;
    bit_d      = bit_q;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = vgaOutColour;

    if (start) begin
      state_d    = S_DRAW;
      lanes_d    = songPattern;
      score_d    = '0;
      step_cnt_d = '0;
      pending_d  = 1'b0;
      lane_idx_d = '0;
      box_d      = '0;
      row_d      = '0;
      col_d      = '0;
      drain_d    = 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (step || pending_q) begin
            state_d   = S_SCORE;
            pending_d = 1'b0;
          end
        end

        S_SCORE: begin
          if (step) begin
            pending_d = 1'b1;
          end
          if (score_sum > SUM_W'({SCORE_W{1'b1}})) begin
            score_d = '1;
          end else begin
            score_d = score_sum[SCORE_W-1:0];
          end
          for (int l = 0; l < LANES; l++) begin
            lanes_d[l*SONG_LEN +: SONG_LEN] = lanes_q[l*SONG_LEN +: SONG_LEN] >> 1;
          end
          step_cnt_d = step_cnt_q + STEP_W'(1);
          if (step_cnt_d == STEP_W'(SONG_LEN)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAW;
          end
        end

        S_DRAW: begin
          if (step) begin
            pending_d = 1'b1;
          end
          // One extra drain cycle lets the final issued pixel plot while still in DRAW.
          if (drain_q) begin
            drain_d = 1'b0;
            state_d = S_WAIT;
          end else begin
            plot_d = 1'b1;
            bit_d  = box_bit;
            x_d    = pix_x;
            y_d    = pix_y;
            if (col_q == PIX_W'(BOX_W - 1)) begin
              col_d = '0;
              if (row_q == PIX_W'(BOX_H - 1)) begin
                row_d = '0;
                if (box_q == BOX_IW'(BOXES - 1)) begin
                  box_d = '0;
                  if (lane_idx_q == LANE_W'(LANES - 1)) begin
                    lane_idx_d = '0;
                    drain_d    = 1'b1;
                  end else begin
                    lane_idx_d = lane_idx_q + LANE_W'(1);
                  end
                end else begin
                  box_d = box_q + BOX_IW'(1);
                end
              end else begin
                row_d = row_q + PIX_W'(1);
              end
            end else begin
              col_d = col_q + PIX_W'(1);
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lanes_q    <= '0;
      score_q    <= '0;
      step_cnt_q <= '0;
      pending_q  <= 1'b0;
      lane_idx_q <= '0;
      box_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      drain_q    <= 1'b0;
      plot_q     <= 1'b0;
      bit_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
    end else begin
      state_q    <= state_d;
      lanes_q    <= lanes_d;
      score_q    <= score_d;
      step_cnt_q <= step_cnt_d;
      pending_q  <= pending_d;
      lane_idx_q <= lane_idx_d;
      box_q      <= box_d;
      row_q      <= row_d;
      col_q      <= col_d;
      drain_q    <= drain_d;
      plot_q     <= plot_d;
      bit_q      <= bit_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
    end
  end

  assign spriteAddr = {row_q[5:0], col_q[5:0]};
  assign vgaOutX    = x_q;
  assign vgaOutY    = y_q;
  assign plot       = plot_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign songDone   = (state_q == S_DONE);
  assign score      = score_q;

endmodule

// File: tb/tb_note_lane_engine.sv
// Bench for note_lane_engine: one default-sized instance for the full-frame geometry
// and a reduced instance for scoring, pending steps and whole-song runs.
module tb_note_lane_engine;

  localparam int S_LANES = 3;
  localparam int S_BOXES = 4;
  localparam int S_LEN   = 20;
  localparam int S_BW    = 4;
  localparam int S_BH    = 3;
  localparam int S_OY    = 10;
  localparam int S_SW    = 3;
  localparam int S_MAX   = 7;
  localparam int S_FRAME = S_LANES * S_BOXES * S_BW * S_BH;
  localparam int B_FRAME = 3 * 4 * 60 * 60;

  typedef struct {
    int plots;
    int bad;
    int pos;
  } frame_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic              b_reset = 1'b0, b_start = 1'b0, b_step = 1'b0;
  logic [3*115-1:0]  b_pattern = '0;
  logic [2:0]        b_notes = 3'b000;
  logic [11:0]       b_addr;
  logic [2:0]        b_colour_in = 3'b010;
  logic [8:0]        b_x;
  logic [7:0]        b_y;
  logic [2:0]        b_col;
  logic              b_plot, b_busy, b_done;
  logic [7:0]        b_score;

  logic                     s_reset = 1'b0, s_start = 1'b0, s_step = 1'b0;
  logic [S_LANES*S_LEN-1:0] s_pattern = '0;
  logic [S_LANES-1:0]       s_notes = '0;
  logic [11:0]              s_addr;
  logic [2:0]               s_colour_in = 3'b000;
  logic [8:0]               s_x;
  logic [7:0]               s_y;
  logic [2:0]               s_col;
  logic                     s_plot, s_busy, s_done;
  logic [S_SW-1:0]          s_score;

  note_lane_engine dut_big (
    .clock(clock), .reset(b_reset), .start(b_start), .step(b_step),
    .songPattern(b_pattern), .notes(b_notes), .spriteAddr(b_addr),
    .spriteColour(b_colour_in), .vgaOutX(b_x), .vgaOutY(b_y),
    .vgaOutColour(b_col), .plot(b_plot), .busy(b_busy), .songDone(b_done),
    .score(b_score)
  );

  note_lane_engine #(
    .LANES(S_LANES), .BOXES(S_BOXES), .SONG_LEN(S_LEN), .BOX_W(S_BW),
    .BOX_H(S_BH), .ORIGIN_Y(S_OY), .SCORE_W(S_SW)
  ) dut (
    .clock(clock), .reset(s_reset), .start(s_start), .step(s_step),
    .songPattern(s_pattern), .notes(s_notes), .spriteAddr(s_addr),
    .spriteColour(s_colour_in), .vgaOutX(s_x), .vgaOutY(s_y),
    .vgaOutColour(s_col), .plot(s_plot), .busy(s_busy), .songDone(s_done),
    .score(s_score)
  );

  function automatic logic [2:0] rom_fn(input int r, input int c);
    return 3'(r * 5 + c * 3 + 1);
  endfunction

  // Synchronous sprite ROM: data follows the address by one clock.
  always @(posedge clock) s_colour_in <= rom_fn(int'(s_addr[11:6]), int'(s_addr[5:0]));

  // Reference song state for the reduced instance.
  logic   s_pat [S_LANES][S_LEN];
  int     s_pos;
  int     s_mscore;
  int     s_pos_q[$];
  frame_t s_log[$];

  int   s_k, s_bad, s_fpos, ml, mc, mr, mcol, idx;
  bit   s_open = 1'b0;
  logic mbit;
  logic [2:0] ecol;

  always @(negedge clock) begin
    if (s_plot === 1'b1) begin
      if (!s_open) begin
        s_open = 1'b1;
        s_k    = 0;
        s_bad  = 0;
        if (s_pos_q.size() > 0) s_fpos = s_pos_q.pop_front();
        else s_fpos = -1;
      end
      ml   = s_k / (S_BOXES * S_BW * S_BH);
      mc   = (s_k % (S_BOXES * S_BW * S_BH)) / (S_BW * S_BH);
      mr   = (s_k % (S_BW * S_BH)) / S_BW;
      mcol = s_k % S_BW;
      if (s_fpos < 0 || ml >= S_LANES) begin
        s_bad++;
      end else begin
        idx  = s_fpos + S_BOXES - 1 - mc;
        mbit = (idx < S_LEN) ? s_pat[ml][idx] : 1'b0;
        ecol = mbit ? rom_fn(mr, mcol) : 3'b111;
        if (s_x !== 9'(mc * S_BW + mcol) || s_y !== 8'(S_OY + ml * S_BH + mr) || s_col !== ecol)
          s_bad++;
      end
      s_k++;
    end else if (s_open) begin
      s_open = 1'b0;
      s_log.push_back('{plots: s_k, bad: s_bad, pos: s_fpos});
    end
  end

  int   b_k, b_bad, b_frames, b_fx, b_fy, b_lx, b_ly, bl, bc, br, bcol;
  bit   b_open = 1'b0;
  logic [2:0] b_ecol;

  always @(negedge clock) begin
    if (b_plot === 1'b1) begin
      if (!b_open) begin
        b_open = 1'b1;
        b_frames++;
        b_fx = int'(b_x);
        b_fy = int'(b_y);
      end
      if (b_k >= B_FRAME) begin
        b_bad++;
      end else begin
        bl   = b_k / 14400;
        bc   = (b_k % 14400) / 3600;
        br   = (b_k % 3600) / 60;
        bcol = b_k % 60;
        b_ecol = b_pattern[bl * 115 + 3 - bc] ? 3'b010 : 3'b111;
        if (b_x !== 9'(bc * 60 + bcol) || b_y !== 8'(60 + bl * 60 + br) || b_col !== b_ecol)
          b_bad++;
      end
      b_lx = int'(b_x);
      b_ly = int'(b_y);
      b_k++;
    end else begin
      b_open = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic s_load_random();
    for (int l = 0; l < S_LANES; l++)
      for (int i = 0; i < S_LEN; i++) s_pat[l][i] = 1'($urandom_range(0, 1));
  endtask

  task automatic s_apply_pattern();
    for (int l = 0; l < S_LANES; l++)
      for (int i = 0; i < S_LEN; i++) s_pattern[l*S_LEN + i] = s_pat[l][i];
  endtask

  task automatic s_begin();
    s_apply_pattern();
    s_pos    = 0;
    s_mscore = 0;
    s_log.delete();
    s_pos_q.delete();
    s_pos_q.push_back(0);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
  endtask

  function automatic void model_step(input logic [2:0] nv);
    int hits = 0;
    if (s_pos < S_LEN)
      for (int l = 0; l < S_LANES; l++) if (s_pat[l][s_pos] && nv[l]) hits++;
    s_mscore = (s_mscore + hits > S_MAX) ? S_MAX : s_mscore + hits;
    s_pos++;
    if (s_pos < S_LEN) s_pos_q.push_back(s_pos);
  endfunction

  // Step from WAIT; notes stay valid through the scoring cycle that follows.
  task automatic s_do_step(input logic [2:0] nv);
    s_notes = nv;
    model_step(nv);
    s_step = 1'b1;
    tick();
    s_step = 1'b0;
    tick();
  endtask

  task automatic s_wait_frame(input int total, output bit ok, output frame_t fr);
    int cyc = 0;
    while (s_log.size() < total && cyc < 2000) begin
      tick();
      cyc++;
    end
    ok = (s_log.size() >= total);
    if (ok) fr = s_log[total-1];
    else fr = '{plots: -1, bad: -1, pos: -1};
  endtask

  task automatic test_reset();
    b_reset = 1'b1;
    s_reset = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({b_plot, b_busy, b_done, b_score, b_x, b_y, b_col, b_addr} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_big: got plot=%b busy=%b done=%b score=%0d x=%0d y=%0d col=%0d addr=%0h, required all zero",
               b_plot, b_busy, b_done, b_score, b_x, b_y, b_col, b_addr);
    end
    n_tests++;
    if ({s_plot, s_busy, s_done, s_score, s_x, s_y, s_col, s_addr} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_small: got plot=%b busy=%b done=%b score=%0d x=%0d y=%0d col=%0d addr=%0h, required all zero",
               s_plot, s_busy, s_done, s_score, s_x, s_y, s_col, s_addr);
    end
    b_reset = 1'b0;
    s_reset = 1'b0;
    s_log.delete();
    s_step = 1'b1;
    tick();
    s_step = 1'b0;
    repeat (8) tick();
    n_tests++;
    if (s_busy !== 1'b0 || s_log.size() != 0 || s_open) begin
      n_fail++;
      $display("[TB] FAIL idle_step: got busy=%b frames=%0d, required busy=0 frames=0", s_busy, s_log.size());
    end
  endtask

  task automatic test_default_frame();
    int cyc = 0;
    for (int i = 0; i < 3*115; i++) b_pattern[i] = 1'($urandom_range(0, 1));
    b_k = 0;
    b_bad = 0;
    b_frames = 0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    while (!(b_k >= B_FRAME && b_plot === 1'b0) && cyc < 50000) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (b_k != B_FRAME || cyc >= 50000) begin
      n_fail++;
      $display("[TB] FAIL big_plot_count: got %0d plots, required %0d", b_k, B_FRAME);
    end
    n_tests++;
    if (b_bad != 0 || b_frames != 1) begin
      n_fail++;
      $display("[TB] FAIL big_pixels: got %0d bad pixels in %0d frames, required 0 in 1", b_bad, b_frames);
    end
    n_tests++;
    if (b_fx != 0 || b_fy != 60) begin
      n_fail++;
      $display("[TB] FAIL big_first_plot: got (%0d,%0d), required (0,60)", b_fx, b_fy);
    end
    n_tests++;
    if (b_lx != 239 || b_ly != 239) begin
      n_fail++;
      $display("[TB] FAIL big_last_plot: got (%0d,%0d), required (239,239)", b_lx, b_ly);
    end
    repeat (20) tick();
    n_tests++;
    if (b_busy !== 1'b1 || b_done !== 1'b0 || b_plot !== 1'b0 || b_k != B_FRAME) begin
      n_fail++;
      $display("[TB] FAIL big_after_frame: got busy=%b done=%b plot=%b plots=%0d, required busy=1 done=0 plot=0 plots=%0d",
               b_busy, b_done, b_plot, b_k, B_FRAME);
    end
  endtask

  task automatic test_reset_mid_draw();
    int n = 0;
    int cyc = 0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    while (n < 1000 && cyc < 3000) begin
      tick();
      cyc++;
      if (b_plot === 1'b1) n++;
    end
    n_tests++;
    if (n != 1000) begin
      n_fail++;
      $display("[TB] FAIL mid_draw_reach: got %0d plots, required 1000", n);
    end
    b_reset = 1'b1;
    b_start = 1'b1;
    tick();
    b_reset = 1'b0;
    b_start = 1'b0;
    n_tests++;
    if ({b_plot, b_busy, b_done, b_score, b_x, b_y, b_col, b_addr} !== '0) begin
      n_fail++;
      $display("[TB] FAIL mid_draw_reset: got plot=%b busy=%b done=%b x=%0d y=%0d col=%0d addr=%0h, required all zero",
               b_plot, b_busy, b_done, b_x, b_y, b_col, b_addr);
    end
    repeat (3) tick();
    n_tests++;
    if (b_plot !== 1'b0 || b_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_draw_idle: got plot=%b busy=%b, required 0 0", b_plot, b_busy);
    end
  endtask

  task automatic test_scoring();
    bit ok;
    frame_t fr;
    s_load_random();
    s_pat[0][0] = 1'b1;
    s_begin();
    s_wait_frame(1, ok, fr);
    n_tests++;
    if (!ok || fr.plots != S_FRAME || fr.bad != 0 || fr.pos != 0) begin
      n_fail++;
      $display("[TB] FAIL score_initial_frame: got plots=%0d bad=%0d pos=%0d, required %0d 0 0", fr.plots, fr.bad, fr.pos, S_FRAME);
    end
    s_do_step(3'b001);
    s_notes = 3'($urandom_range(0, 7));
    s_wait_frame(2, ok, fr);
    n_tests++;
    if (!ok || fr.plots != S_FRAME || fr.bad != 0 || fr.pos != 1) begin
      n_fail++;
      $display("[TB] FAIL score_step_frame: got plots=%0d bad=%0d pos=%0d, required %0d 0 1", fr.plots, fr.bad, fr.pos, S_FRAME);
    end
    n_tests++;
    if (int'(s_score) != s_mscore || s_mscore != 1) begin
      n_fail++;
      $display("[TB] FAIL score_hit: got %0d, required %0d", s_score, s_mscore);
    end
    s_begin();
    s_wait_frame(1, ok, fr);
    s_do_step(3'b000);
    s_wait_frame(2, ok, fr);
    n_tests++;
    if (!ok || int'(s_score) != s_mscore || s_mscore != 0) begin
      n_fail++;
      $display("[TB] FAIL score_miss: got %0d, required %0d", s_score, s_mscore);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    frame_t fr;
    s_load_random();
    for (int l = 0; l < S_LANES; l++)
      for (int i = 0; i < 5; i++) s_pat[l][i] = 1'b1;
    s_begin();
    s_wait_frame(1, ok, fr);
    for (int i = 0; i < 4; i++) begin
      s_do_step(3'b111);
      s_wait_frame(i + 2, ok, fr);
      n_tests++;
      if (!ok || int'(s_score) != s_mscore || fr.bad != 0) begin
        n_fail++;
        $display("[TB] FAIL saturate_step%0d: got score=%0d bad=%0d, required score=%0d bad=0", i, s_score, fr.bad, s_mscore);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    frame_t fr;
    logic [2:0] nv;
    nv = 3'($urandom_range(0, 7));
    s_load_random();
    s_begin();
    s_wait_frame(1, ok, fr);
    s_do_step(nv);
    repeat (10) tick();
    model_step(nv);
    s_step = 1'b1;
    tick();
    s_step = 1'b0;
    repeat (5) tick();
    s_step = 1'b1;
    tick();
    s_step = 1'b0;
    s_wait_frame(3, ok, fr);
    n_tests++;
    if (!ok || fr.plots != S_FRAME || fr.bad != 0 || fr.pos != 2) begin
      n_fail++;
      $display("[TB] FAIL pending_frame: got plots=%0d bad=%0d pos=%0d, required %0d 0 2", fr.plots, fr.bad, fr.pos, S_FRAME);
    end
    repeat (300) tick();
    n_tests++;
    if (s_log.size() != 3 || s_busy !== 1'b1 || s_log[1].bad != 0) begin
      n_fail++;
      $display("[TB] FAIL pending_single: got %0d frames busy=%b, required 3 frames busy=1", s_log.size(), s_busy);
    end
    n_tests++;
    if (int'(s_score) != s_mscore) begin
      n_fail++;
      $display("[TB] FAIL pending_score: got %0d, required %0d", s_score, s_mscore);
    end
    s_do_step(nv);
    s_wait_frame(4, ok, fr);
    n_tests++;
    if (!ok || fr.bad != 0 || fr.pos != 3) begin
      n_fail++;
      $display("[TB] FAIL pending_counter: got bad=%0d pos=%0d, required 0 3", fr.bad, fr.pos);
    end
  endtask

  task automatic test_full_song();
    bit ok;
    frame_t fr;
    int frames;
    s_load_random();
    s_begin();
    s_wait_frame(1, ok, fr);
    for (int i = 1; i <= S_LEN; i++) begin
      s_do_step(3'($urandom_range(0, 7)));
      s_notes = 3'($urandom_range(0, 7));
      if (i < S_LEN) begin
        s_wait_frame(i + 1, ok, fr);
        n_tests++;
        if (!ok || fr.plots != S_FRAME || fr.bad != 0 || int'(s_score) != s_mscore) begin
          n_fail++;
          $display("[TB] FAIL song_step%0d: got plots=%0d bad=%0d score=%0d, required %0d 0 %0d",
                   i, fr.plots, fr.bad, s_score, S_FRAME, s_mscore);
        end
      end
    end
    repeat (3) tick();
    n_tests++;
    if (s_done !== 1'b1 || s_busy !== 1'b0 || int'(s_score) != s_mscore) begin
      n_fail++;
      $display("[TB] FAIL song_done: got done=%b busy=%b score=%0d, required 1 0 %0d", s_done, s_busy, s_score, s_mscore);
    end
    frames = s_log.size();
    s_step = 1'b1;
    tick();
    s_step = 1'b0;
    repeat (300) tick();
    n_tests++;
    if (s_log.size() != frames || s_open || s_done !== 1'b1 || int'(s_score) != s_mscore) begin
      n_fail++;
      $display("[TB] FAIL song_hold: got frames=%0d done=%b score=%0d, required frames=%0d done=1 score=%0d",
               s_log.size(), s_done, s_score, frames, s_mscore);
    end
    s_load_random();
    s_begin();
    n_tests++;
    if (s_done !== 1'b0 || s_score !== '0 || s_busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL song_restart: got done=%b score=%0d busy=%b, required 0 0 1", s_done, s_score, s_busy);
    end
    s_wait_frame(1, ok, fr);
    n_tests++;
    if (!ok || fr.plots != S_FRAME || fr.bad != 0 || fr.pos != 0) begin
      n_fail++;
      $display("[TB] FAIL song_restart_frame: got plots=%0d bad=%0d pos=%0d, required %0d 0 0", fr.plots, fr.bad, fr.pos, S_FRAME);
    end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_reset_mid_draw();
    test_scoring();
    test_saturation();
    test_back_to_back();
    test_full_song();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
